// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Pipeline register between instruction decode and execute.
//   - Captures register-file read data, immediate, PC+4, register
//     specifiers and decoded control from decode every cycle.
//   - Same-cycle write-back bypass: a register being written by WB on this
//     edge is captured with the WB value instead of the stale RF read.
//   - Load-use hazard detection: when EX holds a load whose destination is
//     read by the decode instruction, Stall holds the front end for one
//     cycle and a bubble is inserted into EX.
//   - Branch flush squashes the decode instruction (bubble, no stall).
//   - Saturating count of inserted bubbles since reset.
//
// Ports
//   Clk, Reset             clock, synchronous active-high reset
//   Flush                  squash instruction currently in decode
//   ID_*                   decode-stage operands, specifiers and control
//   WB_RegWrite/WriteRegister/WriteData   write-back port for bypass
//   Stall                  combinational front-end hold (load-use)
//   EX_*                   registered operands/specifiers/control for EX
//   BubbleCount            saturating bubble counter
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [3:0]        ID_ALUOp,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WriteRegister,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic              Stall,
    output logic              EX_Valid,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemToReg,
    output logic              EX_ALUSrc,
    output logic              EX_RegDst,
    output logic [3:0]        EX_ALUOp,
    output logic [CNT_W-1:0]  BubbleCount
);

    // Pipeline state
    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] rd1_q,      rd1_d;
    logic [DATA_W-1:0] rd2_q,      rd2_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [DATA_W-1:0] pc4_q,      pc4_d;
    logic [4:0]        rs_q,       rs_d;
    logic [4:0]        rt_q,       rt_d;
    logic [4:0]        rd_q,       rd_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              alusrc_q,   alusrc_d;
    logic              regdst_q,   regdst_d;
    logic [3:0]        aluop_q,    aluop_d;
    logic [CNT_W-1:0]  bubbles_q,  bubbles_d;

    logic load_use;
    logic byp1;
    logic byp2;
    logic bubble;

    // Load-use hazard: EX holds a valid load to a nonzero register that the
    // decode instruction actually reads.
    always_comb begin
        load_use = valid_q && memread_q && (rt_q != 5'd0) &&
                   ((ID_UsesRs && (ID_Rs == rt_q)) ||
                    (ID_UsesRt && (ID_Rt == rt_q)));
    end

    // A squashed instruction must never hold the front end, and nothing
    // stalls while reset is asserted.
    assign Stall  = load_use && !Flush && !Reset;
    assign bubble = Flush || load_use;

    // Write-back bypass; register 0 is hardwired and never forwarded.
    always_comb begin
        byp1 = WB_RegWrite && (WB_WriteRegister != 5'd0) &&
               (WB_WriteRegister == ID_Rs);
        byp2 = WB_RegWrite && (WB_WriteRegister != 5'd0) &&
               (WB_WriteRegister == ID_Rt);
    end

    // Next-state: bubble clears every EX field; otherwise capture decode.
    always_comb begin
        valid_d    = 1'b0;
        rd1_d      = '0;
        rd2_d      = '0;
        imm_d      = '0;
        pc4_d      = '0;
        rs_d       = '0;
        rt_d       = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        alusrc_d   = 1'b0;
        regdst_d   = 1'b0;
        aluop_d    = '0;
        bubbles_d  = bubbles_q;

        if (bubble) begin
            // Saturate at all-ones; never wrap.
            if (bubbles_q != '1) begin
                bubbles_d = bubbles_q + CNT_W'(1);
            end
        end else begin
            valid_d    = 1'b1;
            rd1_d      = byp1 ? WB_WriteData : ID_ReadData1;
            rd2_d      = byp2 ? WB_WriteData : ID_ReadData2;
            imm_d      = ID_Imm;
            pc4_d      = ID_PCPlus4;
            rs_d       = ID_Rs;
            rt_d       = ID_Rt;
            rd_d       = ID_Rd;
            regwrite_d = ID_RegWrite;
            memread_d  = ID_MemRead;
            memwrite_d = ID_MemWrite;
            memtoreg_d = ID_MemToReg;
            alusrc_d   = ID_ALUSrc;
            regdst_d   = ID_RegDst;
            aluop_d    = ID_ALUOp;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q    <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc4_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            regdst_q   <= 1'b0;
            aluop_q    <= '0;
            bubbles_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc4_q      <= pc4_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            regdst_q   <= regdst_d;
            aluop_q    <= aluop_d;
            bubbles_q  <= bubbles_d;
        end
    end

    assign EX_Valid     = valid_q;
    assign EX_ReadData1 = rd1_q;
    assign EX_ReadData2 = rd2_q;
    assign EX_Imm       = imm_q;
    assign EX_PCPlus4   = pc4_q;
    assign EX_Rs        = rs_q;
    assign EX_Rt        = rt_q;
    assign EX_Rd        = rd_q;
    assign EX_RegWrite  = regwrite_q;
    assign EX_MemRead   = memread_q;
    assign EX_MemWrite  = memwrite_q;
    assign EX_MemToReg  = memtoreg_q;
    assign EX_ALUSrc    = alusrc_q;
    assign EX_RegDst    = regdst_q;
    assign EX_ALUOp     = aluop_q;
    assign BubbleCount  = bubbles_q;

endmodule
